// File: rtl/ecc_decode_pipe.sv
// rtl/ecc_decode_pipe.sv - multi-lane SECDED decoder with optional output register, saturating error counters and sticky first-error log
package ecc_pkg;
  function automatic int get_parity_width(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic int get_cw_width(input int dw);
    return dw + get_parity_width(dw);
  endfunction
endpackage

module ecc_decode_pipe #(
  parameter int DataWidth     = 32,
  parameter int NumLanes      = 4,
  parameter int PipeReg       = 1,
  parameter int CntWidth      = 16,
  parameter int ParityWidth   = ecc_pkg::get_parity_width(DataWidth),
  parameter int CodeWordWidth = ecc_pkg::get_cw_width(DataWidth),
  parameter int LaneIdxWidth  = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [NumLanes*(CodeWordWidth+1)-1:0] data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [NumLanes*DataWidth-1:0]      data_o,
  output logic [NumLanes-1:0]                single_err_o,
  output logic [NumLanes-1:0]                parity_err_o,
  output logic [NumLanes-1:0]                double_err_o,
  input  logic                               clear_i,
  output logic [CntWidth-1:0]                corr_cnt_o,
  output logic [CntWidth-1:0]                uncorr_cnt_o,
  output logic                               log_valid_o,
  output logic [LaneIdxWidth-1:0]            log_lane_o,
  output logic [ParityWidth-1:0]             log_syndrome_o,
  output logic                               log_double_o
);

  localparam int CW        = CodeWordWidth;
  localparam int LW        = CW + 1;
  localparam int IncWidth  = $clog2(NumLanes + 1);
  localparam int SumWidth  = ((CntWidth > IncWidth) ? CntWidth : IncWidth) + 1;

  logic [NumLanes*DataWidth-1:0]   dec_data;
  logic [NumLanes-1:0]             dec_single;
  logic [NumLanes-1:0]             dec_parity;
  logic [NumLanes-1:0]             dec_double;
  logic [NumLanes*ParityWidth-1:0] dec_syn;
  logic [NumLanes*ParityWidth-1:0] out_syn;

  // Per-lane syndrome, classification, single-bit fix and data extraction.
  always_comb begin
    logic [LW-1:0]          cw;
    logic [ParityWidth-1:0] syn;
    logic [CW-1:0]          fixed;
    logic                   par;
    int                     di;
    dec_data   = '0;
    dec_single = '0;
    dec_parity = '0;
    dec_double = '0;
    dec_syn    = '0;
    for (int k = 0; k < NumLanes; k++) begin
      cw  = data_i[k*LW +: LW];
      syn = '0;
      for (int pos = 1; pos <= CW; pos++) begin
        if (cw[pos-1]) syn = syn ^ ParityWidth'(pos);
      end
      par = ^cw;
      dec_single[k] = (syn != '0) && par;
      dec_parity[k] = (syn == '0) && par;
      dec_double[k] = (syn != '0) && !par;
      // A syndrome beyond the codeword length matches no position, so nothing flips.
      fixed = cw[CW-1:0];
      for (int pos = 1; pos <= CW; pos++) begin
        if (dec_single[k] && (syn == ParityWidth'(pos))) fixed[pos-1] = ~fixed[pos-1];
      end
      di = 0;
      for (int pos = 1; pos <= CW; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          dec_data[k*DataWidth + di] = fixed[pos-1];
          di++;
        end
      end
      dec_syn[k*ParityWidth +: ParityWidth] = syn;
    end
  end

  generate
    if (PipeReg != 0) begin : g_reg
      logic                            valid_q;
      logic [NumLanes*DataWidth-1:0]   data_q;
      logic [NumLanes-1:0]             single_q;
      logic [NumLanes-1:0]             parity_q;
      logic [NumLanes-1:0]             double_q;
      logic [NumLanes*ParityWidth-1:0] syn_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_q  <= 1'b0;
          data_q   <= '0;
          single_q <= '0;
          parity_q <= '0;
          double_q <= '0;
          syn_q    <= '0;
        end else if (ready_o) begin
          valid_q <= valid_i;
          if (valid_i) begin
            data_q   <= dec_data;
            single_q <= dec_single;
            parity_q <= dec_parity;
            double_q <= dec_double;
            syn_q    <= dec_syn;
          end
        end
      end

      assign ready_o      = ~valid_q | ready_i;
      assign valid_o      = valid_q;
      assign data_o       = data_q;
      assign single_err_o = single_q;
      assign parity_err_o = parity_q;
      assign double_err_o = double_q;
      assign out_syn      = syn_q;
    end else begin : g_comb
      assign ready_o      = ready_i;
      assign valid_o      = valid_i;
      assign data_o       = dec_data;
      assign single_err_o = dec_single;
      assign parity_err_o = dec_parity;
      assign double_err_o = dec_double;
      assign out_syn      = dec_syn;
    end
  endgenerate

  logic                    hs;
  logic [IncWidth-1:0]     corr_inc;
  logic [IncWidth-1:0]     uncorr_inc;
  logic                    err_hit;
  logic [LaneIdxWidth-1:0] err_lane;
  logic [ParityWidth-1:0]  err_syn;
  logic                    err_dbl;
  logic                    dbl_hit;
  logic [LaneIdxWidth-1:0] dbl_lane;
  logic [ParityWidth-1:0]  dbl_syn;

  assign hs = valid_o & ready_i;

  // Walk lanes from the top down so the last hit written is the lowest index.
  always_comb begin
    corr_inc   = '0;
    uncorr_inc = '0;
    err_hit    = 1'b0;
    err_lane   = '0;
    err_syn    = '0;
    err_dbl    = 1'b0;
    dbl_hit    = 1'b0;
    dbl_lane   = '0;
    dbl_syn    = '0;
    for (int k = NumLanes - 1; k >= 0; k--) begin
      corr_inc   = corr_inc + IncWidth'(single_err_o[k] | parity_err_o[k]);
      uncorr_inc = uncorr_inc + IncWidth'(double_err_o[k]);
      if (single_err_o[k] | parity_err_o[k] | double_err_o[k]) begin
        err_hit  = 1'b1;
        err_lane = LaneIdxWidth'(k);
        err_syn  = out_syn[k*ParityWidth +: ParityWidth];
        err_dbl  = double_err_o[k];
      end
      if (double_err_o[k]) begin
        dbl_hit  = 1'b1;
        dbl_lane = LaneIdxWidth'(k);
        dbl_syn  = out_syn[k*ParityWidth +: ParityWidth];
      end
    end
  end

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                  input logic [IncWidth-1:0] b);
    logic [SumWidth-1:0] s;
    s = SumWidth'(a) + SumWidth'(b);
    if (s > SumWidth'({CntWidth{1'b1}})) return {CntWidth{1'b1}};
    return s[CntWidth-1:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (clear_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (hs) begin
      corr_cnt_o   <= sat_add(corr_cnt_o, corr_inc);
      uncorr_cnt_o <= sat_add(uncorr_cnt_o, uncorr_inc);
    end
  end

  // First error is captured; one upgrade to a double error is allowed, then it freezes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      log_valid_o    <= 1'b0;
      log_lane_o     <= '0;
      log_syndrome_o <= '0;
      log_double_o   <= 1'b0;
    end else if (clear_i) begin
      log_valid_o    <= 1'b0;
      log_lane_o     <= '0;
      log_syndrome_o <= '0;
      log_double_o   <= 1'b0;
    end else if (hs) begin
      if (!log_valid_o && err_hit) begin
        log_valid_o    <= 1'b1;
        log_lane_o     <= err_lane;
        log_syndrome_o <= err_syn;
        log_double_o   <= err_dbl;
      end else if (log_valid_o && !log_double_o && dbl_hit) begin
        log_lane_o     <= dbl_lane;
        log_syndrome_o <= dbl_syn;
        log_double_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// tb/tb_ecc_decode_pipe.sv - scoreboard bench for ecc_decode_pipe (default counters plus a 2-bit saturating instance)
module tb_ecc_decode_pipe;
  localparam int DW = 32;
  localparam int NL = 4;
  localparam int PW = 6;
  localparam int CW = 38;
  localparam int LW = CW + 1;
  localparam int LIW = 2;

  typedef struct {
    logic [NL*DW-1:0] data;
    logic [NL-1:0]    single;
    logic [NL-1:0]    parity;
    logic [NL-1:0]    dbl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic valid_i;
  logic ready_i;
  logic clear_i;
  logic [NL*LW-1:0] data_i;

  logic             ready_o, valid_o, log_valid_o, log_double_o;
  logic [NL*DW-1:0] data_o;
  logic [NL-1:0]    single_err_o, parity_err_o, double_err_o;
  logic [15:0]      corr_cnt_o, uncorr_cnt_o;
  logic [LIW-1:0]   log_lane_o;
  logic [PW-1:0]    log_syndrome_o;

  logic             s_ready_o, s_valid_o, s_log_valid_o, s_log_double_o;
  logic [NL*DW-1:0] s_data_o;
  logic [NL-1:0]    s_single_err_o, s_parity_err_o, s_double_err_o;
  logic [1:0]       s_corr_cnt_o, s_uncorr_cnt_o;
  logic [LIW-1:0]   s_log_lane_o;
  logic [PW-1:0]    s_log_syndrome_o;

  int n_compared = 0;
  int n_mismatched = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;
  exp_t sb[$];
  exp_t cur_exp;
  logic [NL*LW-1:0] cur_in;

  always #5 clk = ~clk;

  ecc_decode_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .single_err_o(single_err_o),
    .parity_err_o(parity_err_o), .double_err_o(double_err_o), .clear_i(clear_i),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o), .log_valid_o(log_valid_o),
    .log_lane_o(log_lane_o), .log_syndrome_o(log_syndrome_o), .log_double_o(log_double_o)
  );

  ecc_decode_pipe #(.CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(s_ready_o), .data_i(data_i),
    .valid_o(s_valid_o), .ready_i(ready_i), .data_o(s_data_o), .single_err_o(s_single_err_o),
    .parity_err_o(s_parity_err_o), .double_err_o(s_double_err_o), .clear_i(clear_i),
    .corr_cnt_o(s_corr_cnt_o), .uncorr_cnt_o(s_uncorr_cnt_o), .log_valid_o(s_log_valid_o),
    .log_lane_o(s_log_lane_o), .log_syndrome_o(s_log_syndrome_o), .log_double_o(s_log_double_o)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] encode(input logic [DW-1:0] d);
    logic [LW-1:0] c;
    logic b;
    int di;
    c = '0;
    di = 0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[di];
        di++;
      end
    end
    for (int i = 0; i < PW; i++) begin
      b = 1'b0;
      for (int pos = 1; pos <= CW; pos++)
        if (((pos >> i) & 1) == 1) b = b ^ c[pos-1];
      c[(1 << i) - 1] = b;
    end
    c[CW] = ^c[CW-1:0];
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [LW-1:0] c);
    logic [DW-1:0] d;
    int di;
    d = '0;
    di = 0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = c[pos-1];
        di++;
      end
    end
    return d;
  endfunction

  task automatic begin_beat();
    for (int k = 0; k < NL; k++) cur_in[k*LW +: LW] = encode('0);
    cur_exp.data   = '0;
    cur_exp.single = '0;
    cur_exp.parity = '0;
    cur_exp.dbl    = '0;
  endtask

  // et: 0 none, 1 single at b1, 2 double at b1/b2, 3 overall parity bit
  task automatic set_lane(input int k, input logic [DW-1:0] d, input int et, input int b1, input int b2);
    logic [LW-1:0] c;
    c = encode(d);
    cur_exp.data[k*DW +: DW] = d;
    cur_exp.single[k] = (et == 1);
    cur_exp.dbl[k]    = (et == 2);
    cur_exp.parity[k] = (et == 3);
    case (et)
      1: c[b1] = ~c[b1];
      2: begin c[b1] = ~c[b1]; c[b2] = ~c[b2]; cur_exp.data[k*DW +: DW] = extract(c); end
      3: c[CW] = ~c[CW];
      default: ;
    endcase
    cur_in[k*LW +: LW] = c;
  endtask

  task automatic send_beat();
    int n;
    bit done;
    data_i = cur_in;
    valid_i = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (ready_o) begin
        sb.push_back(cur_exp);
        exp_corr += $countones(cur_exp.single | cur_exp.parity);
        exp_uncorr += $countones(cur_exp.dbl);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    valid_i = 1'b0;
    if (!done) check_eq("send_timeout", 0, 1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_corr"}, corr_cnt_o, exp_corr);
    check_eq({tag, "_uncorr"}, uncorr_cnt_o, exp_uncorr);
    check_eq({tag, "_sat_corr"}, s_corr_cnt_o, (exp_corr > 3) ? 3 : exp_corr);
    check_eq({tag, "_sat_uncorr"}, s_uncorr_cnt_o, (exp_uncorr > 3) ? 3 : exp_uncorr);
  endtask

  task automatic check_log(input string tag, input logic v, input int lane, input int syn, input logic d);
    check_eq({tag, "_log_valid"}, log_valid_o, v);
    check_eq({tag, "_log_lane"}, log_lane_o, lane);
    check_eq({tag, "_log_syn"}, log_syndrome_o, syn);
    check_eq({tag, "_log_double"}, log_double_o, d);
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("data", data_o, e.data);
        check_eq("single", single_err_o, e.single);
        check_eq("parity", parity_err_o, e.parity);
        check_eq("double", double_err_o, e.dbl);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int b0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0; data_i = '0;
    begin_beat();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_ready_o", ready_o, 1);
    check_eq("rst_data_o", data_o, 0);
    check_counts("rst");
    check_log("rst", 0, 0, 0, 0);
    @(posedge clk); #1;

    begin_beat();
    send_beat(); drain();
    check_counts("t1");
    check_log("t1", 0, 0, 0, 0);

    begin_beat(); set_lane(2, '0, 1, 5, 0);
    send_beat(); drain();
    check_counts("t2");
    check_log("t2", 1, 2, 6, 0);

    begin_beat(); set_lane(1, '0, 2, 0, 1);
    send_beat(); drain();
    check_counts("t3");
    check_log("t3", 1, 1, 3, 1);
    begin_beat(); set_lane(3, 32'h0000_a5a5, 1, 10, 0);
    send_beat(); drain();
    check_counts("t3b");
    check_log("t3b", 1, 1, 3, 1);

    begin_beat(); set_lane(0, 32'hdead_beef, 3, 0, 0);
    send_beat(); drain();
    check_counts("t4");

    for (int i = 0; i < 8; i++) begin
      begin_beat();
      for (int k = 0; k < NL; k++) begin
        int et, b1, b2;
        et = $urandom_range(0, 3);
        b1 = $urandom_range(0, CW - 1);
        b2 = $urandom_range(0, CW);
        if (b2 == b1) b2 = CW;
        set_lane(k, $urandom, et, b1, b2);
      end
      send_beat();
    end
    drain();
    check_counts("rand");
    check_log("rand", 1, 1, 3, 1);

    c0 = exp_corr;
    ready_i = 1'b0;
    begin_beat(); set_lane(3, 32'h1234_5678, 1, 20, 0);
    send_beat();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid_o", valid_o, 1);
      check_eq("stall_ready_o", ready_o, 0);
      check_eq("stall_single", single_err_o, 4'b1000);
      check_eq("stall_data", data_o, cur_exp.data);
      check_eq("stall_corr", corr_cnt_o, c0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    drain();
    check_eq("release_corr", corr_cnt_o, c0 + 1);
    drain();
    check_eq("release_once_corr", corr_cnt_o, c0 + 1);
    check_eq("release_valid_o", valid_o, 0);

    clear_i = 1'b1; drain(); clear_i = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    check_counts("clr");
    check_log("clr", 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      begin_beat();
      b0 = $urandom_range(0, CW - 1);
      set_lane(0, $urandom, 1, b0, 0);
      for (int k = 1; k < NL; k++) set_lane(k, $urandom, 1, $urandom_range(0, CW - 1), 0);
      send_beat(); drain();
      check_counts("sat");
      if (i == 0) check_log("sat", 1, 0, b0 + 1, 0);
    end

    begin_beat(); set_lane(2, 32'hcafe_f00d, 2, 3, 7);
    send_beat();
    clear_i = 1'b1; drain(); clear_i = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    check_counts("clr_hs");
    check_log("clr_hs", 0, 0, 0, 0);
    drain();
    check_eq("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/ecc_decode_pipe.md
Name: ecc_decode_pipe

Overview:
Multi-lane, optionally registered SECDED decoder with a valid/ready stream interface. Each lane decodes one extended-Hamming codeword per beat and reports per-lane error flags. Saturating counters track corrected and uncorrectable errors, and a sticky log captures the first error. The block sits between ECC-protected SRAM/bus read paths and consumers, and feeds status registers.

Parameters:
DataWidth, 32, data bits per lane
NumLanes, 4, independent codewords per beat (>=1)
PipeReg, 1, 1 = one registered output stage; 0 = combinational pass-through
CntWidth, 16, width of each error counter
ParityWidth, ecc_pkg::get_parity_width(DataWidth), derived; do not override
CodeWordWidth, ecc_pkg::get_cw_width(DataWidth), derived; do not override
LaneIdxWidth, max(1,$clog2(NumLanes)), derived

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i&&ready_o
data_i  in  NumLanes*(CodeWordWidth+1)  lane k at [k*(CW+1) +: CW+1]; bit CW = overall parity
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
data_o  out  NumLanes*DataWidth  corrected data, lane k at [k*DataWidth +: DataWidth]
single_err_o  out  NumLanes  correctable error in codeword body, per lane
parity_err_o  out  NumLanes  error in overall parity bit only, per lane
double_err_o  out  NumLanes  uncorrectable error, per lane
clear_i  in  1  synchronous clear of counters and log
corr_cnt_o  out  CntWidth  lanes with single or parity error, saturating
uncorr_cnt_o  out  CntWidth  lanes with double error, saturating
log_valid_o  out  1  log holds an error
log_lane_o  out  LaneIdxWidth  lane of logged error
log_syndrome_o  out  ParityWidth  syndrome of logged error
log_double_o  out  1  logged error is uncorrectable

Behaviour:
- Code layout per lane: Hamming positions 1..CW map to bits 0..CW-1. Power-of-two positions hold parity; the rest hold data in ascending order. Syndrome bit i = XOR of bits whose position has bit i set. p = XOR of all CW+1 bits.
- Classification: syn==0,p==0 -> none. syn!=0,p==1 -> single; flip bit syn-1 (syn>CW: flag single, no flip). syn==0,p==1 -> parity. syn!=0,p==0 -> double; data uncorrected.
- Error flags and data_o are all qualified by valid_o. They are mutually exclusive per lane.
- PipeReg=1: one register stage holding decoded data, flags and syndromes. ready_o = ~valid_q | ready_i. Latency 1 cycle. Full throughput with ready_i=1. Outputs stay stable while valid_o&&~ready_i.
- PipeReg=0: valid_o=valid_i, ready_o=ready_i, outputs combinational from data_i, latency 0.
- Statistics update only on output handshake (valid_o&&ready_i), at most once per beat.
- Counter increment = popcount of (single|parity) lanes, resp. double lanes. Saturating add: result = min(cnt+inc, 2^CntWidth-1). No wrap.
- Log when log_valid_o==0: on a handshake beat with any error, capture the lowest-index erroneous lane. Store lane, syndrome, double flag, and set log_valid_o.
- Log when log_valid_o==1 and log_double_o==0: a beat with a double error overwrites the log with the lowest-index double lane, then the log freezes.
- Log when log_double_o==1: no further updates until clear_i.
- clear_i: next cycle, counters=0, log_valid_o=0, log fields=0. Clear has priority over a same-cycle handshake; that beat's errors are neither counted nor logged. The beat itself still transfers.
- Reset: valid_o=0, ready_o=1 (PipeReg=1), counters=0, log_valid_o=log_lane_o=log_syndrome_o=log_double_o=0, data/flag registers=0. Reset mid-operation drops any held beat.

Test Plan:
1. DW=32 (PW=6, CW=38), all-zero codewords on 4 lanes -> data_o=0, all flags 0, counters 0, log_valid_o=0.
2. Lane 2: bit 5 flipped (position 6) -> single_err_o=4'b0100, lane 2 data 0 after 1 cycle, corr_cnt_o=1. Log: lane 2, syndrome 6, log_double_o=0.
3. Then lane 1: bits 0 and 1 flipped -> double_err_o[1]=1, uncorr_cnt_o=1. Log overwritten: lane 1, syndrome 3, double 1. A later single error leaves the log unchanged.
4. Lane 0: bit 38 flipped -> parity_err_o[0]=1, syndrome 0, data unchanged, corr_cnt_o increments.
5. ready_i=0 for 3 cycles with an error beat held -> data_o/flags stable, ready_o=0, counter increments exactly once at release.
6. CntWidth=2, four beats each with 4 single-error lanes -> corr_cnt_o=3 after beat 1 and stays 3. clear_i asserted with a handshake -> counters 0, log empty, beat still delivered.
